rf_writeback: RTL and testbench

Write-back arbiter that drives the single write port of the register file. It merges results from two producers into one registered write per cycle: the single-cycle ALU path and a long-latency path (load/store unit, mul/div). Long-latency results are buffered in a small FIFO and drained in cycles the ALU does not use. Writes to x0 are dropped.

---
 rtl/rf_wb_pkg.sv | 24 ++
 rtl/wb_fifo.sv | 81 ++++++++
 rtl/rf_writeback.sv | 127 ++++++++++++
 tb/tb_rf_writeback.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_wb_pkg.sv
// rf_wb_pkg: shared types for the register-file write-back arbiter.
//   WB_DATA_W / WB_ADDR_W : default register data / index widths
//   REG_ZERO              : index of the hard-wired zero register (x0)
//   wb_req_t              : one write request {rd, data}
//   wb_src_e              : which producer owns the write port this cycle
package rf_wb_pkg;

  localparam int unsigned WB_DATA_W = 32;
  localparam int unsigned WB_ADDR_W = $clog2(WB_DATA_W);

  localparam logic [WB_ADDR_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [WB_ADDR_W-1:0] rd;
    logic [WB_DATA_W-1:0] data;
  } wb_req_t;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_ALU,
    SRC_LNG
  } wb_src_e;

endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: synchronous FIFO of write-back requests.
//   Clk    : clock, rising edge
//   reset  : asynchronous active-low clear (pointers, count, storage)
//   push   : write din at tail (ignored when full)
//   pop    : drop head (ignored when empty)
//   din    : request to enqueue
//   head   : request at head, valid when !empty
//   count  : occupancy 0..DEPTH
//   full   : count == DEPTH
//   empty  : count == 0
module wb_fifo
  import rf_wb_pkg::*;
#(
  parameter type         req_t = wb_req_t,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   Clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  req_t                   din,
  output req_t                   head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  req_t          mem_q [DEPTH];
  req_t          mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_push  = push && !full;
    do_pop   = pop && !empty;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    // Simultaneous push and pop leaves occupancy unchanged.
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/rf_writeback.sv
// rf_writeback: drives the single register-file write port from two producers.
// The single-cycle ALU result is written directly; long-latency results
// (LSU, mul/div) are queued in a FIFO and drained when the ALU is idle, or
// forcibly when the FIFO is full. Writes to x0 are consumed but not issued.
//   Clk, reset            : clock; asynchronous active-low reset
//   alu_valid/ready/rd/data : ALU result handshake
//   lng_valid/ready/rd/data : long-latency result handshake (into FIFO)
//   RFwrite, RegW, dataW  : registered register-file write port
//   fifo_count            : long-path FIFO occupancy
module rf_writeback
  import rf_wb_pkg::*;
#(
  parameter int unsigned dataWidth    = 32,
  parameter int unsigned AddressWidth = $clog2(dataWidth),
  parameter int unsigned DEPTH        = 4
) (
  input  logic                    Clk,
  input  logic                    reset,
  input  logic                    alu_valid,
  output logic                    alu_ready,
  input  logic [AddressWidth-1:0] alu_rd,
  input  logic [dataWidth-1:0]    alu_data,
  input  logic                    lng_valid,
  output logic                    lng_ready,
  input  logic [AddressWidth-1:0] lng_rd,
  input  logic [dataWidth-1:0]    lng_data,
  output logic                    RFwrite,
  output logic [AddressWidth-1:0] RegW,
  output logic [dataWidth-1:0]    dataW,
  output logic [$clog2(DEPTH):0]  fifo_count
);

  typedef struct packed {
    logic [AddressWidth-1:0] rd;
    logic [dataWidth-1:0]    data;
  } req_t;

  req_t                    lng_req, fifo_head;
  logic                    fifo_full, fifo_empty;
  logic                    fifo_push, fifo_pop;
  wb_src_e                 src;
  logic [AddressWidth-1:0] sel_rd;
  logic [dataWidth-1:0]    sel_data;

  logic                    rf_write_q, rf_write_d;
  logic [AddressWidth-1:0] reg_w_q, reg_w_d;
  logic [dataWidth-1:0]    data_w_q, data_w_d;

  assign lng_req.rd   = lng_rd;
  assign lng_req.data = lng_data;

  // Both readies depend only on occupancy: when full, the FIFO head owns
  // the write port so the ALU is held off for that cycle.
  assign alu_ready = !fifo_full;
  assign lng_ready = !fifo_full;
  assign fifo_push = lng_valid && lng_ready;
  assign fifo_pop  = (src == SRC_LNG);

  wb_fifo #(
    .req_t (req_t),
    .DEPTH (DEPTH)
  ) u_fifo (
    .Clk   (Clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (lng_req),
    .head  (fifo_head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    src = SRC_NONE;
    if (fifo_full) begin
      src = SRC_LNG;
    end else if (alu_valid) begin
      src = SRC_ALU;
    end else if (!fifo_empty) begin
      src = SRC_LNG;
    end
  end

  always_comb begin
    sel_rd   = '0;
    sel_data = '0;
    case (src)
      SRC_ALU: begin
        sel_rd   = alu_rd;
        sel_data = alu_data;
      end
      SRC_LNG: begin
        sel_rd   = fifo_head.rd;
        sel_data = fifo_head.data;
      end
      default: begin
        sel_rd   = '0;
        sel_data = '0;
      end
    endcase
  end

  // A selected x0 request is consumed but leaves RegW/dataW untouched.
  always_comb begin
    rf_write_d = (src != SRC_NONE) && (sel_rd != AddressWidth'(REG_ZERO));
    reg_w_d    = rf_write_d ? sel_rd   : reg_w_q;
    data_w_d   = rf_write_d ? sel_data : data_w_q;
  end

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      rf_write_q <= 1'b0;
      reg_w_q    <= '0;
      data_w_q   <= '0;
    end else begin
      rf_write_q <= rf_write_d;
      reg_w_q    <= reg_w_d;
      data_w_q   <= data_w_d;
    end
  end

  assign RFwrite = rf_write_q;
  assign RegW    = reg_w_q;
  assign dataW   = data_w_q;

endmodule

// File: tb/tb_rf_writeback.sv
// tb_rf_writeback: directed bench for rf_writeback with a write scoreboard.
// Expected writes are queued as stimulus is driven; a negedge monitor pops
// and compares every observed RFwrite pulse.
module tb_rf_writeback;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 5;
  localparam int unsigned DEPTH = 4;

  typedef struct packed {
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } exp_t;

  logic          Clk = 1'b0;
  logic          reset;
  logic          alu_valid, alu_ready;
  logic [AW-1:0] alu_rd;
  logic [DW-1:0] alu_data;
  logic          lng_valid, lng_ready;
  logic [AW-1:0] lng_rd;
  logic [DW-1:0] lng_data;
  logic          RFwrite;
  logic [AW-1:0] RegW;
  logic [DW-1:0] dataW;
  logic [2:0]    fifo_count;

  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];
  exp_t mon_e;

  always #5 Clk = ~Clk;

  rf_writeback #(
    .dataWidth    (DW),
    .AddressWidth (AW),
    .DEPTH        (DEPTH)
  ) dut (
    .Clk        (Clk),
    .reset      (reset),
    .alu_valid  (alu_valid),
    .alu_ready  (alu_ready),
    .alu_rd     (alu_rd),
    .alu_data   (alu_data),
    .lng_valid  (lng_valid),
    .lng_ready  (lng_ready),
    .lng_rd     (lng_rd),
    .lng_data   (lng_data),
    .RFwrite    (RFwrite),
    .RegW       (RegW),
    .dataW      (dataW),
    .fifo_count (fifo_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [AW-1:0] rd, input logic [DW-1:0] data);
    exp_t e;
    e.rd   = rd;
    e.data = data;
    return e;
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Scoreboard monitor: every write pulse must match the next expected entry.
  always @(negedge Clk) begin
    if (RFwrite === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_write", {27'd0, RegW}, 32'hFFFF_FFFF);
      end else begin
        mon_e = sb.pop_front();
        chk("sb_rd", {27'd0, RegW}, {27'd0, mon_e.rd});
        chk("sb_data", dataW, mon_e.data);
      end
    end
  end

  initial begin
    reset     = 1'b0;
    alu_valid = 1'b0;
    alu_rd    = '0;
    alu_data  = '0;
    lng_valid = 1'b0;
    lng_rd    = '0;
    lng_data  = '0;

    // Reset state
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_rfwrite", {31'd0, RFwrite}, 32'd0);
    chk("rst_regw", {27'd0, RegW}, 32'd0);
    chk("rst_dataw", dataW, 32'd0);
    chk("rst_count", {29'd0, fifo_count}, 32'd0);
    chk("rst_alu_ready", {31'd0, alu_ready}, 32'd1);
    chk("rst_lng_ready", {31'd0, lng_ready}, 32'd1);
    reset = 1'b1;
    tick();
    chk("idle_rfwrite", {31'd0, RFwrite}, 32'd0);

    // ALU only: write visible the cycle after acceptance, then held
    alu_valid = 1'b1;
    alu_rd    = 5'd5;
    alu_data  = 32'hDEAD_BEEF;
    chk("alu_ready", {31'd0, alu_ready}, 32'd1);
    sb.push_back(mk(5'd5, 32'hDEAD_BEEF));
    tick();
    alu_valid = 1'b0;
    chk("alu_rfwrite", {31'd0, RFwrite}, 32'd1);
    chk("alu_regw", {27'd0, RegW}, 32'd5);
    chk("alu_dataw", dataW, 32'hDEAD_BEEF);
    tick();
    chk("alu_hold_rfwrite", {31'd0, RFwrite}, 32'd0);
    chk("alu_hold_regw", {27'd0, RegW}, 32'd5);
    chk("alu_hold_dataw", dataW, 32'hDEAD_BEEF);

    // Long only: count 1 in N+1, write in N+2
    lng_valid = 1'b1;
    lng_rd    = 5'd7;
    lng_data  = 32'h1234_5678;
    chk("lng_ready", {31'd0, lng_ready}, 32'd1);
    sb.push_back(mk(5'd7, 32'h1234_5678));
    tick();
    lng_valid = 1'b0;
    chk("lng_count1", {29'd0, fifo_count}, 32'd1);
    chk("lng_n1_rfwrite", {31'd0, RFwrite}, 32'd0);
    tick();
    chk("lng_rfwrite", {31'd0, RFwrite}, 32'd1);
    chk("lng_regw", {27'd0, RegW}, 32'd7);
    chk("lng_dataw", dataW, 32'h1234_5678);
    chk("lng_count0", {29'd0, fifo_count}, 32'd0);
    tick();

    // Continuous ALU plus 4 long pushes: fill, one-cycle ALU stall, drain
    alu_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      alu_rd    = 5'(20 + i);
      alu_data  = 32'hC000_0000 + 32'(i);
      lng_valid = 1'b1;
      lng_rd    = 5'(1 + i);
      lng_data  = 32'hA000_0000 + 32'(i);
      chk("fill_lng_ready", {31'd0, lng_ready}, 32'd1);
      chk("fill_alu_ready", {31'd0, alu_ready}, 32'd1);
      sb.push_back(mk(alu_rd, alu_data));
      tick();
    end
    lng_valid = 1'b0;
    alu_rd    = 5'd24;
    alu_data  = 32'hC000_0004;
    chk("full_count", {29'd0, fifo_count}, 32'd4);
    chk("full_lng_ready", {31'd0, lng_ready}, 32'd0);
    chk("full_alu_ready", {31'd0, alu_ready}, 32'd0);
    sb.push_back(mk(5'd1, 32'hA000_0000));
    tick();
    chk("stall_alu_ready", {31'd0, alu_ready}, 32'd1);
    chk("stall_count", {29'd0, fifo_count}, 32'd3);
    chk("stall_rfwrite", {31'd0, RFwrite}, 32'd1);
    chk("stall_regw", {27'd0, RegW}, 32'd1);
    sb.push_back(mk(5'd24, 32'hC000_0004));
    tick();
    chk("resume_regw", {27'd0, RegW}, 32'd24);
    alu_rd   = 5'd25;
    alu_data = 32'hC000_0005;
    sb.push_back(mk(5'd25, 32'hC000_0005));
    tick();
    alu_valid = 1'b0;
    chk("drain_start_count", {29'd0, fifo_count}, 32'd3);
    for (int j = 1; j < 4; j++) begin
      sb.push_back(mk(5'(1 + j), 32'hA000_0000 + 32'(j)));
      tick();
    end
    chk("drain_count", {29'd0, fifo_count}, 32'd0);
    chk("drain_regw", {27'd0, RegW}, 32'd4);
    tick();
    chk("drain_idle_rfwrite", {31'd0, RFwrite}, 32'd0);

    // x0 on both paths: consumed, never written
    alu_valid = 1'b1;
    alu_rd    = 5'd0;
    alu_data  = 32'hFFFF_FFFF;
    lng_valid = 1'b1;
    lng_rd    = 5'd0;
    lng_data  = 32'hFFFF_FFFF;
    tick();
    alu_valid = 1'b0;
    lng_valid = 1'b0;
    chk("x0_count1", {29'd0, fifo_count}, 32'd1);
    chk("x0_alu_rfwrite", {31'd0, RFwrite}, 32'd0);
    chk("x0_alu_regw", {27'd0, RegW}, 32'd4);
    chk("x0_alu_dataw", dataW, 32'hA000_0003);
    tick();
    chk("x0_count0", {29'd0, fifo_count}, 32'd0);
    tick();
    chk("x0_lng_rfwrite", {31'd0, RFwrite}, 32'd0);
    chk("x0_lng_regw", {27'd0, RegW}, 32'd4);
    chk("x0_lng_dataw", dataW, 32'hA000_0003);

    // Three buffered entries, then reset mid-cycle
    for (int k = 0; k < 3; k++) begin
      alu_valid = 1'b1;
      alu_rd    = 5'(26 + k);
      alu_data  = 32'hD000_0000 + 32'(k);
      lng_valid = 1'b1;
      lng_rd    = 5'(8 + k);
      lng_data  = 32'hB000_0000 + 32'(k);
      // The last ALU write is cleared by reset before the monitor samples it.
      if (k < 2) sb.push_back(mk(alu_rd, alu_data));
      tick();
    end
    alu_valid = 1'b0;
    lng_valid = 1'b0;
    chk("pre_rst_count", {29'd0, fifo_count}, 32'd3);
    chk("pre_rst_rfwrite", {31'd0, RFwrite}, 32'd1);
    chk("pre_rst_regw", {27'd0, RegW}, 32'd28);
    #2;
    reset = 1'b0;
    #1;
    chk("midrst_rfwrite", {31'd0, RFwrite}, 32'd0);
    chk("midrst_regw", {27'd0, RegW}, 32'd0);
    chk("midrst_dataw", dataW, 32'd0);
    chk("midrst_count", {29'd0, fifo_count}, 32'd0);
    chk("midrst_lng_ready", {31'd0, lng_ready}, 32'd1);
    tick();
    reset = 1'b1;
    for (int m = 0; m < 3; m++) begin
      tick();
      chk("post_rst_count", {29'd0, fifo_count}, 32'd0);
      chk("post_rst_rfwrite", {31'd0, RFwrite}, 32'd0);
    end
    @(negedge Clk);
    #1;
    chk("sb_empty", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
